sap_datapath: RTL and testbench

- Executes the 15-bit control word produced by the CPU's control sequencer.
- Contains PC, MAR/MDR, 16×8 RAM, IR, accumulator A, operand register B, adder/subtractor, output register and the shared 8-bit bus.
- Returns the current opcode (IR[7:4]) to the sequencer, closing the loop.
- Provides a program-load port that fills RAM before the sequencer is released.

---
 rtl/sap_datapath.sv | 140 ++++++++++++++
 tb/tb_sap_datapath.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sap_datapath.sv
// rtl/sap_datapath.sv - SAP-1 style datapath executing the sequencer's 15-bit control word
// Optional ALU carry/zero flags: define SAP_DATAPATH_FLAGS_EN.
module sap_datapath #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [14:0]       ctrl,
    output logic [3:0]        opcode,
    output logic [DATA_W-1:0] out_val,
    output logic [DATA_W-1:0] bus_mon,
    output logic              bus_conflict,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data
`ifdef SAP_DATAPATH_FLAGS_EN
    ,
    output logic              flag_c,
    output logic              flag_z
`endif
);

    logic pc_inc, pc_en, pc_load, mar_ld, mdr_ld, ram_en, ram_ld;
    logic ir_ld, ir_en, a_ld, a_en, sub, alu_en, b_ld, out_ld;

    assign pc_inc = ctrl[14];
    assign pc_en  = ctrl[13];
    assign pc_load = ctrl[12];
    assign mar_ld = ~ctrl[11];
    assign mdr_ld = ~ctrl[10];
    assign ram_en = ~ctrl[9];
    assign ram_ld = ~ctrl[8];
    assign ir_ld  = ~ctrl[7];
    assign ir_en  = ~ctrl[6];
    assign a_ld   = ~ctrl[5];
    assign a_en   = ctrl[4];
    assign sub    = ctrl[3];
    assign alu_en = ctrl[2];
    assign b_ld   = ~ctrl[1];
    assign out_ld = ~ctrl[0];

    logic [ADDR_W-1:0] pc_q, pc_d, mar_q, mar_d;
    logic [DATA_W-1:0] mdr_q, mdr_d, ir_q, ir_d, a_q, a_d, b_q, b_d, out_q, out_d;
    logic              conflict_q, conflict_d;
    logic [DATA_W-1:0] mem [2**ADDR_W];

    logic [DATA_W-1:0] bus, ram_rd;
    logic [DATA_W:0]   alu_ext;
    logic [2:0]        n_drv;

    assign ram_rd = mem[mar_q];

    always_comb begin
        // SUB folds into the carry-in so subtraction is A + ~B + 1
        alu_ext = {1'b0, a_q} + {1'b0, (sub ? ~b_q : b_q)} + (DATA_W+1)'(sub);
        n_drv = 3'(pc_en) + 3'(ram_en) + 3'(ir_en) + 3'(a_en) + 3'(alu_en);

        bus = '0;
        if (pc_en)       bus = {{(DATA_W-ADDR_W){1'b0}}, pc_q};
        else if (ram_en) bus = ram_rd;
        else if (ir_en)  bus = {{(DATA_W-4){1'b0}}, ir_q[3:0]};
        else if (a_en)   bus = a_q;
        else if (alu_en) bus = alu_ext[DATA_W-1:0];

        pc_d = pc_q;
        if (pc_load)     pc_d = bus[ADDR_W-1:0];
        else if (pc_inc) pc_d = pc_q + ADDR_W'(1);

        mar_d = mar_ld ? bus[ADDR_W-1:0] : mar_q;
        mdr_d = mdr_ld ? bus : mdr_q;
        ir_d  = ir_ld  ? bus : ir_q;
        a_d   = a_ld   ? bus : a_q;
        b_d   = b_ld   ? bus : b_q;
        out_d = out_ld ? bus : out_q;
        conflict_d = conflict_q | (n_drv > 3'd1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= '0;
            mar_q      <= '0;
            mdr_q      <= '0;
            ir_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            out_q      <= '0;
            conflict_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            mar_q      <= mar_d;
            mdr_q      <= mdr_d;
            ir_q       <= ir_d;
            a_q        <= a_d;
            b_q        <= b_d;
            out_q      <= out_d;
            conflict_q <= conflict_d;
        end
    end

    // Program port stays live during reset and overrides a colliding ctrl write
    always_ff @(posedge clk) begin
        if (prog_we)
            mem[prog_addr] <= prog_data;
        else if (!rst && ram_ld)
            mem[mar_q] <= mdr_q;
    end

    assign opcode       = ir_q[DATA_W-1:DATA_W-4];
    assign out_val      = out_q;
    assign bus_mon      = bus;
    assign bus_conflict = conflict_q;

`ifdef SAP_DATAPATH_FLAGS_EN
    logic flag_c_q, flag_c_d, flag_z_q, flag_z_d;

    always_comb begin
        flag_c_d = flag_c_q;
        flag_z_d = flag_z_q;
        if (a_ld && alu_en) begin
            flag_c_d = alu_ext[DATA_W];
            flag_z_d = (alu_ext[DATA_W-1:0] == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_c_q <= 1'b0;
            flag_z_q <= 1'b0;
        end else begin
            flag_c_q <= flag_c_d;
            flag_z_q <= flag_z_d;
        end
    end

    assign flag_c = flag_c_q;
    assign flag_z = flag_z_q;
`endif

endmodule

// File: tb/tb_sap_datapath.sv
// tb/tb_sap_datapath.sv - directed self-checking bench for sap_datapath
module tb_sap_datapath;

    localparam logic [14:0] IDLE     = 15'h0FE3;
    localparam logic [14:0] M_PC_INC = 15'h4000;
    localparam logic [14:0] M_PC_EN  = 15'h2000;
    localparam logic [14:0] M_PC_LD  = 15'h1000;
    localparam logic [14:0] M_MAR_LD = 15'h0800;
    localparam logic [14:0] M_MDR_LD = 15'h0400;
    localparam logic [14:0] M_RAM_EN = 15'h0200;
    localparam logic [14:0] M_RAM_LD = 15'h0100;
    localparam logic [14:0] M_IR_EN  = 15'h0040;
    localparam logic [14:0] M_A_LD   = 15'h0020;
    localparam logic [14:0] M_A_EN   = 15'h0010;
    localparam logic [14:0] M_SUB    = 15'h0008;
    localparam logic [14:0] M_ALU_EN = 15'h0004;
    localparam logic [14:0] M_B_LD   = 15'h0002;
    localparam logic [14:0] M_OUT_LD = 15'h0001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [14:0] ctrl = IDLE;
    logic [3:0]  opcode;
    logic [7:0]  out_val, bus_mon;
    logic        bus_conflict;
    logic        prog_we = 1'b0;
    logic [3:0]  prog_addr = '0;
    logic [7:0]  prog_data = '0;
`ifdef SAP_DATAPATH_FLAGS_EN
    logic        flag_c, flag_z;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sap_datapath #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .ctrl         (ctrl),
        .opcode       (opcode),
        .out_val      (out_val),
        .bus_mon      (bus_mon),
        .bus_conflict (bus_conflict),
        .prog_we      (prog_we),
        .prog_addr    (prog_addr),
        .prog_data    (prog_data)
`ifdef SAP_DATAPATH_FLAGS_EN
        ,
        .flag_c       (flag_c),
        .flag_z       (flag_z)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // XOR with the idle word asserts each masked signal regardless of polarity
    task automatic step(input logic [14:0] m);
        @(negedge clk);
        ctrl = IDLE ^ m;
        @(posedge clk);
        #1;
        ctrl = IDLE;
    endtask

    task automatic poke(input logic [3:0] addr, input logic [7:0] data);
        @(negedge clk);
        prog_we = 1'b1;
        prog_addr = addr;
        prog_data = data;
        @(posedge clk);
        #1;
        prog_we = 1'b0;
    endtask

    initial begin
        poke(4'd0, 8'h2E);
        poke(4'd14, 8'h20);
        chk("rst_pc", 32'(dut.pc_q), 32'h0);
        chk("rst_a", 32'(dut.a_q), 32'h0);
        chk("rst_opcode", 32'(opcode), 32'h0);
        chk("rst_out", 32'(out_val), 32'h0);
        chk("rst_conflict", 32'(bus_conflict), 32'h0);
        chk("rst_bus_idle", 32'(bus_mon), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // fetch
        step(15'h27E3 ^ IDLE);
        chk("fetch_mar", 32'(dut.mar_q), 32'h0);
        step(15'h4FE3 ^ IDLE);
        chk("fetch_pc", 32'(dut.pc_q), 32'h1);
        step(15'h0D63 ^ IDLE);
        chk("fetch_ir", 32'(dut.ir_q), 32'h2E);
        chk("fetch_opcode", 32'(opcode), 32'h2);

        // ADD with wrap: 0xF0 + 0x20
        poke(4'd0, 8'hF0);
        step(M_RAM_EN | M_A_LD);
        chk("add_a_pre", 32'(dut.a_q), 32'hF0);
        step(M_IR_EN | M_MAR_LD);
        chk("add_mar", 32'(dut.mar_q), 32'd14);
        step(M_RAM_EN | M_B_LD);
        chk("add_b", 32'(dut.b_q), 32'h20);
        step(M_ALU_EN | M_A_LD);
        chk("add_a", 32'(dut.a_q), 32'h10);
`ifdef SAP_DATAPATH_FLAGS_EN
        chk("add_flag_c", 32'(flag_c), 32'h1);
        chk("add_flag_z", 32'(flag_z), 32'h0);
`endif

        // SUB to zero
        poke(4'd14, 8'h05);
        step(M_RAM_EN | M_A_LD | M_B_LD);
        step(M_SUB | M_ALU_EN | M_A_LD);
        chk("sub_a", 32'(dut.a_q), 32'h0);
`ifdef SAP_DATAPATH_FLAGS_EN
        chk("sub_flag_z", 32'(flag_z), 32'h1);
        chk("sub_flag_c", 32'(flag_c), 32'h1);
`endif

        // STA then OUT
        poke(4'd14, 8'h5A);
        step(M_RAM_EN | M_A_LD);
        poke(4'd14, 8'h07);
        step(M_RAM_EN | M_MAR_LD);
        chk("sta_mar", 32'(dut.mar_q), 32'd7);
        step(M_A_EN | M_MDR_LD);
        step(M_RAM_LD);
        chk("sta_ram7", 32'(dut.mem[7]), 32'h5A);
        step(M_RAM_EN | M_OUT_LD);
        chk("out_val", 32'(out_val), 32'h5A);

        // PC wrap and LOAD-over-INC
        poke(4'd7, 8'h0F);
        step(M_RAM_EN | M_PC_LD);
        chk("pc_load15", 32'(dut.pc_q), 32'hF);
        step(M_PC_INC);
        chk("pc_wrap", 32'(dut.pc_q), 32'h0);
        poke(4'd7, 8'h03);
        step(M_RAM_EN | M_PC_LD | M_PC_INC);
        chk("pc_load_beats_inc", 32'(dut.pc_q), 32'h3);

        // program port beats ctrl write to the same address (MDR holds 0x5A)
        @(negedge clk);
        ctrl = IDLE ^ M_RAM_LD;
        prog_we = 1'b1;
        prog_addr = 4'd7;
        prog_data = 8'hC3;
        @(posedge clk);
        #1;
        ctrl = IDLE;
        prog_we = 1'b0;
        @(negedge clk);
        ctrl = IDLE ^ M_RAM_EN;
        #1;
        chk("collision_bus", 32'(bus_mon), 32'hC3);
        ctrl = IDLE;

        // idle word leaves state alone
        step(15'h0);
        chk("idle_a", 32'(dut.a_q), 32'h5A);
        chk("idle_pc", 32'(dut.pc_q), 32'h3);
        chk("idle_out", 32'(out_val), 32'h5A);

        // bus conflict: PC wins, flag sticky
        @(negedge clk);
        ctrl = IDLE ^ (M_PC_EN | M_A_EN);
        #1;
        chk("conflict_bus_pc", 32'(bus_mon), 32'h03);
        chk("conflict_pre_edge", 32'(bus_conflict), 32'h0);
        @(posedge clk);
        #1;
        ctrl = IDLE;
        chk("conflict_set", 32'(bus_conflict), 32'h1);
        step(15'h0);
        step(15'h0);
        chk("conflict_sticky", 32'(bus_conflict), 32'h1);

        // asynchronous reset between edges
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_pc", 32'(dut.pc_q), 32'h0);
        chk("async_rst_a", 32'(dut.a_q), 32'h0);
        chk("async_rst_out", 32'(out_val), 32'h0);
        chk("async_rst_conflict", 32'(bus_conflict), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
